// File: rtl/stats_uart_reporter.sv
// ============================================================================
// stats_uart_reporter
//
// Purpose:
//   Snapshots the CPU instruction-mix and cycle counters on a start request
//   and sends them off-chip as one 9-byte packet on a UART 8N1 transmit line.
//   Packet order: HEADER, i[15:8], i[7:0], r[15:8], r[7:0], j[15:8], j[7:0],
//   cnt_clk[15:8], cnt_clk[7:0]. Counters are zero-extended to 16 bits.
//   Each byte is framed as: start bit (0), 8 data bits LSB first, stop bit (1).
//   Every bit is held for CLKS_PER_BIT cycles. Bytes follow each other with
//   no idle gap.
//
// Parameters:
//   CNT_W         counter width (1..16)
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   HEADER        first byte of every packet
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-low reset
//   start    in   1      report request, sampled only while idle (IDLE or DONE)
//   i        in   CNT_W  I-type instruction count
//   r        in   CNT_W  R-type instruction count
//   j        in   CNT_W  J-type instruction count
//   cnt_clk  in   CNT_W  cycle count
//   tx       out  1      UART serial output, idles high
//   busy     out  1      high from packet acceptance until the last stop bit ends
//   done     out  1      one-cycle pulse after the last stop bit ends
// ============================================================================
module stats_uart_reporter #(
    parameter int         CNT_W        = 11,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] i,
    input  logic [CNT_W-1:0] r,
    input  logic [CNT_W-1:0] j,
    input  logic [CNT_W-1:0] cnt_clk,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int               TIMER_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BYTE = 4'd8;
    localparam logic [2:0]       LAST_BIT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [TIMER_W-1:0]   bit_timer;
    logic [TIMER_W-1:0]   bit_timer_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic [3:0]           byte_idx;
    logic [3:0]           byte_idx_next;
    logic [7:0]           shift_reg;
    logic [7:0]           shift_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 snap_load;
    logic                 timer_wrap;

    logic [15:0]          i_snap;
    logic [15:0]          r_snap;
    logic [15:0]          j_snap;
    logic [15:0]          clk_snap;

    logic [3:0]           byte_sel;
    logic [7:0]           next_byte;

    // The counters are captured on the accept edge so the inputs may change
    // freely while the packet is on the wire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_snap   <= '0;
            r_snap   <= '0;
            j_snap   <= '0;
            clk_snap <= '0;
        end else if (snap_load) begin
            i_snap   <= 16'(i);
            r_snap   <= 16'(r);
            j_snap   <= 16'(j);
            clk_snap <= 16'(cnt_clk);
        end
    end

    // Selects the byte that follows the current one. The header is loaded
    // directly on accept, so only indices 1..8 come from the snapshot.
    always_comb begin
        byte_sel  = byte_idx + 4'd1;
        next_byte = HEADER;
        case (byte_sel)
            4'd1:    next_byte = i_snap[15:8];
            4'd2:    next_byte = i_snap[7:0];
            4'd3:    next_byte = r_snap[15:8];
            4'd4:    next_byte = r_snap[7:0];
            4'd5:    next_byte = j_snap[15:8];
            4'd6:    next_byte = j_snap[7:0];
            4'd7:    next_byte = clk_snap[15:8];
            4'd8:    next_byte = clk_snap[7:0];
            default: next_byte = HEADER;
        endcase
    end

    // State, timers, shift register and the registered outputs all update
    // together, so tx/busy/done change exactly on the bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_timer <= bit_timer_next;
            bit_idx   <= bit_idx_next;
            byte_idx  <= byte_idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next-state logic. The outputs computed here are the values that tx,
    // busy and done take after the coming edge. The DONE cycle behaves like
    // IDLE for acceptance, so a held start re-arms without a gap cycle.
    always_comb begin
        state_next     = state;
        bit_timer_next = bit_timer;
        bit_idx_next   = bit_idx;
        byte_idx_next  = byte_idx;
        shift_next     = shift_reg;
        tx_next        = tx;
        busy_next      = busy;
        done_next      = 1'b0;
        snap_load      = 1'b0;
        timer_wrap     = (bit_timer == TIMER_MAX);

        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                if (start) begin
                    state_next     = START_BIT;
                    snap_load      = 1'b1;
                    bit_timer_next = '0;
                    bit_idx_next   = '0;
                    byte_idx_next  = '0;
                    shift_next     = HEADER;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
                end
            end

            START_BIT: begin
                bit_timer_next = timer_wrap ? '0 : bit_timer + 1'b1;
                if (timer_wrap) begin
                    state_next   = DATA_BITS;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                end
            end

            DATA_BITS: begin
                bit_timer_next = timer_wrap ? '0 : bit_timer + 1'b1;
                if (timer_wrap) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next   = STOP_BIT;
                        bit_idx_next = '0;
                        tx_next      = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end
            end

            STOP_BIT: begin
                bit_timer_next = timer_wrap ? '0 : bit_timer + 1'b1;
                if (timer_wrap) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_next    = DONE;
                        byte_idx_next = '0;
                        tx_next       = 1'b1;
                        busy_next     = 1'b0;
                        done_next     = 1'b1;
                    end else begin
                        state_next    = START_BIT;
                        byte_idx_next = byte_sel;
                        shift_next    = next_byte;
                        tx_next       = 1'b0;
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                bit_timer_next = '0;
                bit_idx_next   = '0;
                byte_idx_next  = '0;
                tx_next        = 1'b1;
                busy_next      = 1'b0;
            end
        endcase
    end

endmodule
